// File: rtl/dtcm_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dtcm_lsu_pkg
// Brief    : Shared types and constants for the DTCM load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package dtcm_lsu_pkg;

    // DTCM geometry defaults
    localparam int c_DTCM_AW = 14;
    localparam int c_DTCM_DW = 32;
    localparam int c_DTCM_MW = c_DTCM_DW / 8;

    // Access size encodings
    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;
    localparam logic [1:0] c_SZ_ILL  = 2'b11;

    // FSM state encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } lsu_state_e;

    // An access is in error when its size is illegal or it is not naturally aligned
    function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
        logic r;
        r = 1'b0;
        case (size)
            c_SZ_HALF: r = off[0];
            c_SZ_WORD: r = (off != 2'b00);
            c_SZ_ILL:  r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dtcm_lsu_rdata_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_rdata_align
// Brief    : Selects the addressed lane of a RAM word and sign/zero extends it.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_rdata_align
    import dtcm_lsu_pkg::*;
#(
    parameter int DW = c_DTCM_DW
) (
    input  logic [DW-1:0] dout,
    input  logic [1:0]    offset,
    input  logic [1:0]    size,
    input  logic          is_unsigned,
    output logic [DW-1:0] rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane extraction followed by extension according to the access size
    always_comb begin
        w_byte = dout[{offset, 3'b000} +: 8];
        w_half = offset[1] ? dout[31:16] : dout[15:0];
        case (size)
            c_SZ_BYTE: rdata = {{24{~is_unsigned & w_byte[7]}}, w_byte};
            c_SZ_HALF: rdata = {{16{~is_unsigned & w_half[15]}}, w_half};
            default:   rdata = dout;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dtcm_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dtcm_lsu
// Brief    : Single-outstanding load/store unit in front of a 1-cycle DTCM.
// Revision : 1.0 - initial release
// ============================================================================
module dtcm_lsu
    import dtcm_lsu_pkg::*;
#(
    parameter int AW = c_DTCM_AW,
    parameter int DW = c_DTCM_DW,
    parameter int MW = c_DTCM_MW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic          lsu_req_we,
    input  logic [31:0]   lsu_req_addr,
    input  logic [1:0]    lsu_req_size,
    input  logic          lsu_req_unsigned,
    input  logic [31:0]   lsu_req_wdata,
    output logic          lsu_rsp_valid,
    input  logic          lsu_rsp_ready,
    output logic [31:0]   lsu_rsp_rdata,
    output logic          lsu_rsp_err,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic [MW-1:0] ram_wem,
    input  logic [DW-1:0] ram_dout
);

    lsu_state_e    r_state;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_uns;
    logic          r_we;
    logic          r_err;
    logic [31:0]   r_hold;

    logic          w_rsp_hs;
    logic          w_accept;
    logic          w_mis;
    logic [31:0]   w_fmt;
    logic [31:0]   w_acc_data;
    logic          w_unused_addr;

    // Address bits above the DTCM window are deliberately ignored
    assign w_unused_addr = ^lsu_req_addr[31:AW+2];

    assign lsu_rsp_valid = (r_state != ST_IDLE);
    assign w_rsp_hs      = lsu_rsp_valid & lsu_rsp_ready;
    // Reset gates acceptance so nothing reaches the RAM while rst_n is low
    assign lsu_req_ready = rst_n & ((r_state == ST_IDLE) | w_rsp_hs);
    assign w_accept      = lsu_req_valid & lsu_req_ready;
    assign w_mis         = is_misaligned(lsu_req_addr[1:0], lsu_req_size);

    assign ram_we   = w_accept & lsu_req_we & ~w_mis;
    assign ram_addr = w_accept ? lsu_req_addr[AW+1:2] : r_addr;

    // Store lane mask and replicated write data
    always_comb begin
        ram_wem = '0;
        ram_din = lsu_req_wdata;
        case (lsu_req_size)
            c_SZ_BYTE: begin
                ram_wem = MW'(4'b0001 << lsu_req_addr[1:0]);
                ram_din = {4{lsu_req_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                ram_wem = lsu_req_addr[1] ? 4'b1100 : 4'b0011;
                ram_din = {2{lsu_req_wdata[15:0]}};
            end
            c_SZ_WORD: begin
                ram_wem = 4'b1111;
                ram_din = lsu_req_wdata;
            end
            default: begin
                ram_wem = '0;
                ram_din = lsu_req_wdata;
            end
        endcase
    end

    lsu_rdata_align #(
        .DW (DW)
    ) u_align (
        .dout        (ram_dout),
        .offset      (r_off),
        .size        (r_size),
        .is_unsigned (r_uns),
        .rdata       (w_fmt)
    );

    // Stores and errored accesses always return zero data
    assign w_acc_data = (r_we | r_err) ? 32'h0 : w_fmt;

    // Response data: live RAM lane in ACC, captured copy while stalled in HOLD
    always_comb begin
        case (r_state)
            ST_ACC:  lsu_rsp_rdata = w_acc_data;
            ST_HOLD: lsu_rsp_rdata = r_hold;
            default: lsu_rsp_rdata = 32'h0;
        endcase
    end

    assign lsu_rsp_err = lsu_rsp_valid & r_err;

    // Request capture, response holding and state sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_off   <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= lsu_req_addr[AW+1:2];
                r_off  <= lsu_req_addr[1:0];
                r_size <= lsu_req_size;
                r_uns  <= lsu_req_unsigned;
                r_we   <= lsu_req_we;
                r_err  <= w_mis;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) r_state <= ST_ACC;
                end
                ST_ACC: begin
                    if (lsu_rsp_ready) begin
                        r_state <= w_accept ? ST_ACC : ST_IDLE;
                    end else begin
                        r_hold  <= w_acc_data;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (lsu_rsp_ready) r_state <= w_accept ? ST_ACC : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dtcm_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtcm_lsu
// Brief    : Self-checking bench for dtcm_lsu with a byte-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtcm_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_req_we = 1'b0;
    logic [31:0] lsu_req_addr = '0;
    logic [1:0]  lsu_req_size = '0;
    logic        lsu_req_unsigned = 1'b0;
    logic [31:0] lsu_req_wdata = '0;
    logic        lsu_rsp_valid;
    logic        lsu_rsp_ready = 1'b0;
    logic [31:0] lsu_rsp_rdata;
    logic        lsu_rsp_err;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_din;
    logic [3:0]  ram_wem;
    logic [31:0] ram_dout;

    logic [31:0] ram   [0:16383];
    logic [31:0] model [0:16383];

    int n_checks = 0;
    int n_fail   = 0;

    dtcm_lsu u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lsu_req_valid    (lsu_req_valid),
        .lsu_req_ready    (lsu_req_ready),
        .lsu_req_we       (lsu_req_we),
        .lsu_req_addr     (lsu_req_addr),
        .lsu_req_size     (lsu_req_size),
        .lsu_req_unsigned (lsu_req_unsigned),
        .lsu_req_wdata    (lsu_req_wdata),
        .lsu_rsp_valid    (lsu_rsp_valid),
        .lsu_rsp_ready    (lsu_rsp_ready),
        .lsu_rsp_rdata    (lsu_rsp_rdata),
        .lsu_rsp_err      (lsu_rsp_err),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_din          (ram_din),
        .ram_wem          (ram_wem),
        .ram_dout         (ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM with per-byte write mask
    always @(posedge clk) begin
        if (ram_we) begin
            for (int k = 0; k < 4; k++)
                if (ram_wem[k]) ram[ram_addr][8*k +: 8] <= ram_din[8*k +: 8];
        end
        ram_dout <= ram[ram_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] a, input logic [1:0] sz);
        int unsigned n;
        if (sz == 2'd3) return 1'b1;
        n = 1 << sz;
        return (a % n) != 0;
    endfunction

    // Load result from the model word: pick bytes, then extend by value range
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input bit uns);
        int unsigned nb, off, v;
        if (sz == 2'd2) return w;
        nb  = 8 << sz;
        off = (a % 4) / (1 << sz) * (1 << sz);
        v   = (w >> (8 * off)) & ((1 << nb) - 1);
        if (!uns && v >= (1 << (nb - 1))) v = v - (1 << nb);
        return v;
    endfunction

    // One request with a given number of response stall cycles; returns response data
    task automatic do_req(input bit we, input logic [31:0] a, input logic [1:0] sz,
                          input bit uns, input logic [31:0] wd, input int stall,
                          output logic [31:0] got);
        bit          err;
        int          idx;
        int          off;
        logic [31:0] exp_rd;
        logic [3:0]  exp_mask;
        logic [31:0] exp_din;
        logic [31:0] din_mask;
        err = ref_err(a, sz);
        idx = int'(a[15:2]);
        off = int'(a[1:0]);
        exp_rd = (we || err) ? 32'h0 : ref_load(model[idx], a, sz, uns);
        exp_mask = '0;
        exp_din = '0;
        din_mask = '0;
        if (!err) begin
            for (int k = 0; k < 4; k++) begin
                if (k >= off && k < off + (1 << sz)) begin
                    exp_mask[k] = 1'b1;
                    exp_din[8*k +: 8] = wd[8*(k-off) +: 8];
                    din_mask[8*k +: 8] = 8'hFF;
                end
            end
        end
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_we = we; lsu_req_addr = a;
        lsu_req_size = sz; lsu_req_unsigned = uns; lsu_req_wdata = wd;
        lsu_rsp_ready = 1'b0;
        #1;
        check_val("req_ready", {31'b0, lsu_req_ready}, 32'd1);
        check_val("ram_addr", {18'b0, ram_addr}, idx);
        check_val("ram_we", {31'b0, ram_we}, {31'b0, we && !err});
        if (we && !err) begin
            check_val("ram_wem", {28'b0, ram_wem}, {28'b0, exp_mask});
            check_val("ram_din", ram_din & din_mask, exp_din);
        end
        @(posedge clk);
        if (we && !err)
            for (int k = 0; k < 4; k++) if (exp_mask[k]) model[idx][8*k +: 8] = exp_din[8*k +: 8];
        @(negedge clk);
        lsu_req_valid = 1'b0;
        got = '0;
        for (int s = 0; s <= stall; s++) begin
            lsu_rsp_ready = (s == stall);
            #1;
            check_val("rsp_valid", {31'b0, lsu_rsp_valid}, 32'd1);
            check_val("rsp_rdata", lsu_rsp_rdata, exp_rd);
            check_val("rsp_err", {31'b0, lsu_rsp_err}, {31'b0, err});
            check_val("ready_in_rsp", {31'b0, lsu_req_ready}, {31'b0, s == stall});
            got = lsu_rsp_rdata;
            @(posedge clk);
            @(negedge clk);
        end
        lsu_rsp_ready = 1'b0;
        #1;
        check_val("rsp_done", {31'b0, lsu_rsp_valid}, 32'd0);
        check_val("ram_word", ram[idx], model[idx]);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 16384; i++) begin
            ram[i] = (i < 64) ? $urandom : 32'h0;
            model[i] = ram[i];
        end

        // Reset state, with a store presented that must not be written
        lsu_req_valid = 1'b1; lsu_req_we = 1'b1; lsu_req_addr = 32'h0; lsu_req_size = 2'd2;
        lsu_req_wdata = 32'hCAFE_F00D;
        #2;
        check_val("rst_rsp_valid", {31'b0, lsu_rsp_valid}, 32'd0);
        check_val("rst_rsp_err", {31'b0, lsu_rsp_err}, 32'd0);
        check_val("rst_rsp_rdata", lsu_rsp_rdata, 32'd0);
        check_val("rst_ram_we", {31'b0, ram_we}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check_val("rst_no_write", ram[0], model[0]);
        check_val("post_rst_ready", {31'b0, lsu_req_ready}, 32'd1);

        // Byte store at 0x6
        do_req(1'b1, 32'h0000_0006, 2'd0, 1'b0, 32'h0000_00A5, 0, got);
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_we = 1'b1; lsu_req_addr = 32'h6; lsu_req_size = 2'd0;
        lsu_req_wdata = 32'h0000_00A5;
        #1;
        check_val("byte_din_full", ram_din, 32'hA5A5_A5A5);
        check_val("byte_wem", {28'b0, ram_wem}, 32'h4);
        check_val("byte_addr", {18'b0, ram_addr}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        lsu_req_valid = 1'b0; lsu_rsp_ready = 1'b1;
        #1;
        check_val("byte_rsp_err", {31'b0, lsu_rsp_err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        lsu_rsp_ready = 1'b0;

        // Signed and unsigned half loads
        ram[1] = 32'h8001_7FFF; model[1] = 32'h8001_7FFF;
        do_req(1'b0, 32'h6, 2'd1, 1'b0, 32'h0, 0, got);
        check_val("half_signed", got, 32'hFFFF_8001);
        do_req(1'b0, 32'h6, 2'd1, 1'b1, 32'h0, 2, got);
        check_val("half_unsigned", got, 32'h0000_8001);

        // Misaligned word store
        do_req(1'b1, 32'h2, 2'd2, 1'b0, 32'h1111_2222, 1, got);
        check_val("mis_rdata", got, 32'h0);

        // Back-to-back word loads
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 32'h0; lsu_req_size = 2'd2;
        lsu_rsp_ready = 1'b1;
        #1;
        check_val("b2b_ready0", {31'b0, lsu_req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        lsu_req_addr = 32'h4;
        #1;
        check_val("b2b_ready1", {31'b0, lsu_req_ready}, 32'd1);
        check_val("b2b_rsp0", lsu_rsp_rdata, model[0]);
        @(posedge clk);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        #1;
        check_val("b2b_valid1", {31'b0, lsu_rsp_valid}, 32'd1);
        check_val("b2b_rsp1", lsu_rsp_rdata, model[1]);
        @(posedge clk);
        @(negedge clk);
        lsu_rsp_ready = 1'b0;
        #1;
        check_val("b2b_idle", {31'b0, lsu_rsp_valid}, 32'd0);

        // Back-pressure with a pending request
        ram[2] = 32'h1234_5678; model[2] = 32'h1234_5678;
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8; lsu_req_size = 2'd2; lsu_req_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lsu_req_addr = 32'h0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check_val("bp_ready", {31'b0, lsu_req_ready}, 32'd0);
            check_val("bp_hold", lsu_rsp_rdata, 32'h1234_5678);
            @(posedge clk);
            @(negedge clk);
        end
        lsu_rsp_ready = 1'b1;
        #1;
        check_val("bp_hs_ready", {31'b0, lsu_req_ready}, 32'd1);
        check_val("bp_hs_data", lsu_rsp_rdata, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        #1;
        check_val("bp_next", lsu_rsp_rdata, model[0]);
        @(posedge clk);
        @(negedge clk);
        lsu_rsp_ready = 1'b0;

        // Reset during ACC, with a store presented while reset is low
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h10; lsu_req_size = 2'd2; lsu_req_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lsu_req_we = 1'b1; lsu_req_addr = 32'h14; lsu_req_wdata = 32'hDEAD_BEEF;
        #1;
        check_val("acc_valid", {31'b0, lsu_rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_acc_valid", {31'b0, lsu_rsp_valid}, 32'd0);
        check_val("rst_acc_we", {31'b0, ram_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        lsu_req_valid = 1'b0; lsu_req_we = 1'b0;
        rst_n = 1'b1;
        check_val("rst_acc_ram", ram[5], model[5]);
        for (int s = 0; s < 3; s++) begin
            #1;
            check_val("rst_no_rsp", {31'b0, lsu_rsp_valid}, 32'd0);
            @(negedge clk);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            a  = {16'($urandom), 8'h00, 8'($urandom)};
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
            do_req(1'($urandom), a, sz, 1'($urandom), $urandom, $urandom_range(0, 3), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
